// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared widths and stream-stage state type for the DNN datapath
package dnn_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;

    // Accumulator wide enough for 2**addr_width full-scale signed products
    function automatic int acc_width(input int word_width, input int addr_width);
        return 2 * word_width + addr_width;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } stream_state_e;

endpackage

// File: rtl/mul_signed.sv
// rtl/mul_signed.sv - combinational signed WORD_WIDTH x WORD_WIDTH multiplier
module mul_signed
    import dnn_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic signed [WORD_WIDTH-1:0]   a,
    input  logic signed [WORD_WIDTH-1:0]   b,
    output logic signed [2*WORD_WIDTH-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - signed multiply-accumulate over VEC_LEN beats with registered result handshake
module mac_accum
    import dnn_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int VEC_LEN    = 16,
    parameter int ACC_WIDTH  = acc_width(WORD_WIDTH, ADDR_WIDTH),
    parameter bit RELU_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic [WORD_WIDTH-1:0] weight_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(VEC_LEN - 1);

    stream_state_e                 state;
    stream_state_e                 state_nxt;
    logic [ADDR_WIDTH-1:0]         cnt;
    logic signed [2*WORD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic                          accept;
    logic                          last_beat;

    mul_signed #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_mul (
        .a($signed(data_in)),
        .b($signed(weight_in)),
        .p(prod)
    );

    assign prod_ext  = {{(ACC_WIDTH - 2*WORD_WIDTH){prod[2*WORD_WIDTH-1]}}, prod};
    assign in_ready  = (state != HOLD);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    // First beat of a vector starts a fresh sum rather than adding to stale acc
    assign sum       = (state == ACCUM) ? acc + prod_ext : prod_ext;
    assign last_beat = (state == IDLE) ? (VEC_LEN == 1) : (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = last_beat ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                out_valid <= 1'b0;
                acc       <= '0;
            end
        end else if (accept) begin
            acc <= sum;
            if (last_beat) begin
                cnt       <= '0;
                data_out  <= (RELU_EN && sum[ACC_WIDTH-1]) ? '0 : sum;
                out_valid <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// tb/tb_mac_accum.sv - self-checking bench for mac_accum (plain and ReLU instances)
module tb_mac_accum;

    localparam int VL = 16;
    localparam int AW = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   data_in;
    logic [15:0]   weight_in;
    logic          in_valid;
    logic          out_ready;
    logic          in_ready, in_ready_r;
    logic [AW-1:0] data_out, data_out_r;
    logic          out_valid, out_valid_r;
    logic          busy, busy_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_accum #(.VEC_LEN(VL), .RELU_EN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .weight_in(weight_in),
        .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    mac_accum #(.VEC_LEN(VL), .RELU_EN(1'b1)) u_dut_relu (
        .clk(clk), .rst(rst), .data_in(data_in), .weight_in(weight_in),
        .in_valid(in_valid), .in_ready(in_ready_r), .data_out(data_out_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .busy(busy_r)
    );

    typedef struct {
        string  name;
        int     a;         // data_in per beat (ignored when ramp)
        int     b;         // weight_in per beat
        bit     ramp;      // data_in = beat index
        int     mode;      // 0 back-to-back, 1 alternate bubbles, 2 random bubbles
        int     stall;     // cycles out_ready held low after the result
        longint exp_raw;
        longint exp_relu;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input string name, input logic [15:0] da [VL],
                           input logic [15:0] wa [VL], input int mode,
                           input int stall, input longint exp);
        int     i;
        int     guard;
        logic   acc_now;
        longint exp_r;
        exp_r     = (exp < 0) ? 64'sd0 : exp;
        i         = 0;
        guard     = 0;
        out_ready = (stall == 0);
        while (i < VL && guard < 400) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard[0] == 1'b0);
                default: in_valid = ($urandom_range(3) != 0);
            endcase
            data_in   = da[i];
            weight_in = wa[i];
            acc_now   = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc_now) begin
                i++;
                if (i < VL) check({name, "_early_valid"}, longint'(out_valid), 0);
            end
        end
        if (i < VL) begin
            check({name, "_timeout"}, longint'(i), longint'(VL));
            in_valid = 1'b0;
            return;
        end
        check({name, "_out_valid"}, longint'(out_valid), 1);
        check({name, "_data_out"}, longint'($signed(data_out)), exp);
        check({name, "_relu_valid"}, longint'(out_valid_r), 1);
        check({name, "_relu_out"}, longint'($signed(data_out_r)), exp_r);
        check({name, "_in_ready_hold"}, longint'(in_ready), 0);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            data_in   = 16'($urandom);
            weight_in = 16'($urandom);
            @(posedge clk); #1;
            check({name, "_stall_valid"}, longint'(out_valid), 1);
            check({name, "_stall_data"}, longint'($signed(data_out)), exp);
            check({name, "_stall_ready"}, longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_post_valid"}, longint'(out_valid), 0);
        check({name, "_post_busy"}, longint'(busy), 0);
        check({name, "_post_ready"}, longint'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t          tbl [6];
        logic [15:0]   da [VL];
        logic [15:0]   wa [VL];
        longint        exp;

        tbl[0] = '{"ones",     1,          1,          1'b0, 0, 0, 64'sd16,           64'sd16};
        tbl[1] = '{"signed",   -2,         3,          1'b0, 0, 0, -64'sd96,          64'sd0};
        tbl[2] = '{"extreme",  -32768,     -32768,     1'b0, 0, 0, 64'sd17179869184,  64'sd17179869184};
        tbl[3] = '{"minmax",   32767,      -32768,     1'b0, 0, 2, -64'sd17179344896, 64'sd0};
        tbl[4] = '{"backpres", 1,          1,          1'b0, 0, 5, 64'sd16,           64'sd16};
        tbl[5] = '{"bubbles",  0,          1,          1'b1, 1, 0, 64'sd120,          64'sd120};

        rst       = 1'b0;
        in_valid  = 1'b1;
        data_in   = 16'd7;
        weight_in = 16'd7;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_data_out", longint'(data_out), 0);
        in_valid = 1'b0;
        rst      = 1'b1;

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < VL; j++) begin
                da[j] = tbl[t].ramp ? 16'(j) : 16'(tbl[t].a);
                wa[j] = 16'(tbl[t].b);
            end
            run_vec(tbl[t].name, da, wa, tbl[t].mode, tbl[t].stall, tbl[t].exp_raw);
            check({tbl[t].name, "_relu_last"}, longint'($signed(data_out_r)), tbl[t].exp_relu);
        end

        // Reset partway through a vector must drop the 7 accumulated beats
        in_valid  = 1'b1;
        data_in   = 16'd1;
        weight_in = 16'd1;
        repeat (7) @(posedge clk);
        #1;
        check("midrst_busy_before", longint'(busy), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_busy", longint'(busy), 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int j = 0; j < VL; j++) begin
            da[j] = 16'd1;
            wa[j] = 16'd1;
        end
        run_vec("after_rst", da, wa, 0, 0, 64'sd16);

        // Randomized vectors against a plain arithmetic dot-product model
        for (int r = 0; r < 12; r++) begin
            exp = 0;
            for (int j = 0; j < VL; j++) begin
                da[j] = 16'($urandom);
                wa[j] = 16'($urandom);
                exp += longint'($signed(da[j])) * longint'($signed(wa[j]));
            end
            run_vec($sformatf("rand%0d", r), da, wa, 2, int'($urandom_range(0, 3)), exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
